// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD sequencers: read FSM states,
// default HD44780 timing at 50 MHz, and the controller command/flag constants.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ENAB_HI,
    GAP,
    ENAB_LO,
    HOLD,
    DONE
  } readState_t;

  // Default timing in 20 ns clocks.
  localparam int DEFAULT_SETUP_CYCLES       = 2;
  localparam int DEFAULT_ENABLE_HIGH_CYCLES = 12;
  localparam int DEFAULT_NIBBLE_GAP_CYCLES  = 38;
  localparam int DEFAULT_HOLD_CYCLES        = 1;
  localparam int DEFAULT_MAX_POLLS          = 1000;

  localparam int TIMER_WIDTH = 16;

  // Busy flag position in the BF/AC byte.
  localparam int LCD_BF_BIT = 7;

  // Controller commands used by the init and write paths.
  localparam logic [7:0] LCD_CMD_CLEAR        = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME         = 8'h02;
  localparam logic [7:0] LCD_CMD_ENTRY_MODE   = 8'h06;
  localparam logic [7:0] LCD_CMD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] LCD_CMD_FUNCTION_SET = 8'h28;

  // A state lasting N clocks loads N-1 so the timer reads zero in its last clock.
  function automatic logic [TIMER_WIDTH-1:0] cyclesToLoad(input int cycles);
    return (cycles > 0) ? TIMER_WIDTH'(cycles - 1) : '0;
  endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter that times one FSM state; parks at zero when expired.
module lcd_cycle_timer
  import lcd_pkg::*;
(
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iLoad,
  input  logic [TIMER_WIDTH-1:0] iLoadValue,
  output logic                   oExpired
);

  logic [TIMER_WIDTH-1:0] count;

  // Reload on request, otherwise count down toward zero and stay there.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (iLoad) begin
      count <= iLoadValue;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign oExpired = (count == '0);

endmodule

// File: rtl/lcd_read_strobe.sv
// LCD read sequencer: releases the 4-bit bus, strobes E twice to read one
// byte (high nibble first) and optionally re-reads until the busy flag clears.
// Outputs are registered from the current state, so pins lag the FSM by one clock.
module lcd_read_strobe
  import lcd_pkg::*;
#(
  parameter int SETUP_CYCLES       = DEFAULT_SETUP_CYCLES,
  parameter int ENABLE_HIGH_CYCLES = DEFAULT_ENABLE_HIGH_CYCLES,
  parameter int NIBBLE_GAP_CYCLES  = DEFAULT_NIBBLE_GAP_CYCLES,
  parameter int HOLD_CYCLES        = DEFAULT_HOLD_CYCLES,
  parameter int MAX_POLLS          = DEFAULT_MAX_POLLS
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPoll,
  input  logic [3:0] iLCD_Data,
  output logic       oLCD_Enabled,
  output logic       oLCD_RW,
  output logic       oLCD_RS,
  output logic       oLCD_DataOE,
  output logic       oBusy,
  output logic [7:0] oReadData,
  output logic       oReadDone,
  output logic       oTimeout
);

  readState_t             state;
  readState_t             stateNext;
  logic                   rsLatched;
  logic                   pollLatched;
  logic                   lowNibbleNext;
  logic [TIMER_WIDTH-1:0] pollCount;
  logic [7:0]             byteReg;
  logic                   timerLoad;
  logic [TIMER_WIDTH-1:0] timerValue;
  logic                   timerExpired;
  logic                   pollAgain;
  logic                   active;

  // Re-read only while BF is set and the count after this read is below the limit.
  assign pollAgain = pollLatched && byteReg[LCD_BF_BIT]
                     && ((pollCount + 1'b1) < TIMER_WIDTH'(MAX_POLLS));

  assign active = state inside {SETUP, ENAB_HI, GAP, ENAB_LO, HOLD};

  lcd_cycle_timer timer (
    .Clock     (Clock),
    .Reset     (Reset),
    .iLoad     (timerLoad),
    .iLoadValue(timerValue),
    .oExpired  (timerExpired)
  );

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state decode and timer reload on every state change.
  // NOTE: each output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    stateNext  = state;
    timerValue = '0;
    unique case (state)
      IDLE:    if (iStart)       stateNext = SETUP;
      SETUP:   if (timerExpired) stateNext = ENAB_HI;
      ENAB_HI: if (timerExpired) stateNext = GAP;
      GAP:     if (timerExpired) stateNext = lowNibbleNext ? ENAB_LO : ENAB_HI;
      ENAB_LO: if (timerExpired) stateNext = HOLD;
      HOLD:    if (timerExpired) stateNext = pollAgain ? GAP : DONE;
      DONE:                      stateNext = IDLE;
      default:                   stateNext = IDLE;
    endcase
    timerLoad = (stateNext != state);
    case (stateNext)
      SETUP:            timerValue = cyclesToLoad(SETUP_CYCLES);
      ENAB_HI, ENAB_LO: timerValue = cyclesToLoad(ENABLE_HIGH_CYCLES);
      GAP:              timerValue = cyclesToLoad(NIBBLE_GAP_CYCLES);
      HOLD:             timerValue = cyclesToLoad(HOLD_CYCLES);
      default:          timerValue = '0;
    endcase
  end

  // Operation context: latched request, nibble sequencing and poll count.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rsLatched     <= 1'b0;
      pollLatched   <= 1'b0;
      lowNibbleNext <= 1'b0;
      pollCount     <= '0;
    end else begin
      if (state == IDLE && iStart) begin
        rsLatched     <= iRS;
        pollLatched   <= iPoll;
        lowNibbleNext <= 1'b0;
        pollCount     <= '0;
      end
      if (state == ENAB_HI && stateNext == GAP)  lowNibbleNext <= 1'b1;
      if (state == ENAB_LO && stateNext == HOLD) lowNibbleNext <= 1'b0;
      if (state == HOLD && stateNext != HOLD)    pollCount     <= pollCount + 1'b1;
    end
  end

  // Capture the bus on the edge where the registered E falls.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      byteReg <= 8'h00;
    end else if (oLCD_Enabled && state == GAP) begin
      byteReg[7:4] <= iLCD_Data;
    end else if (oLCD_Enabled && state == HOLD) begin
      byteReg[3:0] <= iLCD_Data;
    end
  end

  // Pin and status registers decoded from the current state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oLCD_Enabled <= 1'b0;
      oLCD_RW      <= 1'b0;
      oLCD_RS      <= 1'b0;
      oLCD_DataOE  <= 1'b1;
      oBusy        <= 1'b0;
      oReadData    <= 8'h00;
      oReadDone    <= 1'b0;
      oTimeout     <= 1'b0;
    end else begin
      oLCD_Enabled <= state inside {ENAB_HI, ENAB_LO};
      oLCD_RW      <= active;
      oLCD_RS      <= active && rsLatched;
      oLCD_DataOE  <= !active;
      oBusy        <= active;
      oReadDone    <= (state == DONE);
      oTimeout     <= (state == DONE) && pollLatched && byteReg[LCD_BF_BIT];
      if (state == DONE) oReadData <= byteReg;
    end
  end

endmodule

// File: tb/tb_lcd_read_strobe.sv
// Bench for lcd_read_strobe: a timeline model of expected pins per clock,
// an LCD nibble responder, and directed scenarios with literal anchors.
module tb_lcd_read_strobe;

  localparam int SETUP   = 2;
  localparam int EH      = 12;
  localparam int NG      = 38;
  localparam int HOLDC   = 1;
  localparam int POLLS   = 3;
  localparam int REREAD  = HOLDC + NG + EH + NG + EH;  // extra clocks per repeated read
  localparam int MAXC    = 4096;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       iStart = 1'b0;
  logic       iRS = 1'b0;
  logic       iPoll = 1'b0;
  logic [3:0] iLCD_Data = 4'h0;
  logic       oLCD_Enabled, oLCD_RW, oLCD_RS, oLCD_DataOE, oBusy, oReadDone, oTimeout;
  logic [7:0] oReadData;

  lcd_read_strobe #(
    .SETUP_CYCLES      (SETUP),
    .ENABLE_HIGH_CYCLES(EH),
    .NIBBLE_GAP_CYCLES (NG),
    .HOLD_CYCLES       (HOLDC),
    .MAX_POLLS         (POLLS)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .iStart      (iStart),
    .iRS         (iRS),
    .iPoll       (iPoll),
    .iLCD_Data   (iLCD_Data),
    .oLCD_Enabled(oLCD_Enabled),
    .oLCD_RW     (oLCD_RW),
    .oLCD_RS     (oLCD_RS),
    .oLCD_DataOE (oLCD_DataOE),
    .oBusy       (oBusy),
    .oReadData   (oReadData),
    .oReadDone   (oReadDone),
    .oTimeout    (oTimeout)
  );

  always #5 Clock = ~Clock;

  // Index of the most recent rising edge; read at negedges.
  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Expected value of each output for the clock that starts at edge t.
  bit         expE[MAXC];
  bit         expRW[MAXC];
  bit         expRS[MAXC];
  bit         expDone[MAXC];
  bit         expTo[MAXC];
  logic [7:0] expData[MAXC];

  // An operation accepted at edge k: RW from k+1, first E rise after SETUP
  // clocks, each read is two EH-clock pulses NG clocks apart, repeated reads
  // follow HOLD+GAP later, done one clock after the last hold.
  function automatic void scheduleOp(int k, int nReads, bit rs, logic [7:0] b, bit to);
    int rise1;
    int doneT;
    int base;
    rise1 = k + 1 + SETUP;
    doneT = rise1 + EH + NG + EH + HOLDC + (nReads - 1) * REREAD;
    for (int t = k + 1; t < doneT; t++) begin
      expRW[t] = 1'b1;
      expRS[t] = rs;
    end
    for (int r = 0; r < nReads; r++) begin
      base = rise1 + r * REREAD;
      for (int t = base; t < base + EH; t++) expE[t] = 1'b1;
      for (int t = base + EH + NG; t < base + 2 * EH + NG; t++) expE[t] = 1'b1;
    end
    expDone[doneT] = 1'b1;
    expTo[doneT]   = to;
    for (int t = doneT; t < MAXC; t++) expData[t] = b;
  endfunction

  // Reset wipes any pending operation and the returned byte.
  function automatic void clearFrom(int t0);
    for (int t = t0; t < MAXC; t++) begin
      expE[t] = 1'b0; expRW[t] = 1'b0; expRS[t] = 1'b0;
      expDone[t] = 1'b0; expTo[t] = 1'b0; expData[t] = 8'h00;
    end
  endfunction

  // LCD responder: presents the next queued nibble on every E rise.
  logic [3:0] nibQ[$];
  int pulseCnt = 0;
  always @(posedge oLCD_Enabled) begin
    pulseCnt++;
    if (nibQ.size() > 0) iLCD_Data = nibQ.pop_front();
    else                 iLCD_Data = 4'h0;
  end

  // Per-cycle comparison against the model plus protocol invariants.
  int   lastDoneCyc = -1;
  int   doneCnt = 0;
  logic lastDoneTo = 1'b0;
  logic prevE = 1'b0, prevRW = 1'b0, prevRS = 1'b0;
  always @(negedge Clock) begin
    if (cyc < MAXC) begin
      check("outs{E,RW,RS,OE,Busy,Done,Timeout}",
            32'({oLCD_Enabled, oLCD_RW, oLCD_RS, oLCD_DataOE, oBusy, oReadDone, oTimeout}),
            32'({expE[cyc], expRW[cyc], expRS[cyc], ~expRW[cyc], expRW[cyc], expDone[cyc], expTo[cyc]}));
      check("readData", 32'(oReadData), 32'(expData[cyc]));
    end
    if (oLCD_RW)      check("inv_rw_implies_oe_low", 32'(oLCD_DataOE), 32'd0);
    if (oLCD_Enabled) check("inv_e_implies_rw", 32'(oLCD_RW), 32'd1);
    if (prevE && oLCD_Enabled)
      check("inv_rw_rs_stable_while_e", 32'({oLCD_RW, oLCD_RS}), 32'({prevRW, prevRS}));
    if (oReadDone) begin
      lastDoneCyc = cyc;
      lastDoneTo  = oTimeout;
      doneCnt++;
    end
    prevE  = oLCD_Enabled;
    prevRW = oLCD_RW;
    prevRS = oLCD_RS;
  end

  task automatic toCycle(input int c);
    while (cyc < c) @(negedge Clock);
  endtask

  // Present a one-clock start at the current negedge; k is the sampling edge.
  task automatic startOp(input bit rs, input bit poll, input int nReads,
                         input logic [7:0] b, input bit to, output int k);
    iRS    = rs;
    iPoll  = poll;
    iStart = 1'b1;
    k      = cyc + 1;
    scheduleOp(k, nReads, rs, b, to);
    @(negedge Clock);
    iStart = 1'b0;
  endtask

  int k, k2, p0, d0;

  initial begin
    for (int t = 0; t < MAXC; t++) expData[t] = 8'h00;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    toCycle(6);

    // Single read of BF/AC; input changes after start must not matter.
    nibQ = '{4'hB, 4'h2};
    p0 = pulseCnt;
    startOp(1'b0, 1'b0, 1, 8'hB2, 1'b0, k);
    iRS   = 1'b1;
    iPoll = 1'b1;
    toCycle(k + 70);
    check("t1_done_latency", 32'(lastDoneCyc - k), 32'd66);
    check("t1_data", 32'(oReadData), 32'h0000_00B2);
    check("t1_pulses", 32'(pulseCnt - p0), 32'd2);

    // Poll: BF set twice, then clear.
    nibQ = '{4'h9, 4'hA, 4'hC, 4'h3, 4'h0, 4'h5};
    p0 = pulseCnt;
    startOp(1'b0, 1'b1, 3, 8'h05, 1'b0, k);
    iPoll = 1'b0;
    toCycle(k + 66 + 2 * REREAD + 4);
    check("t2_done_latency", 32'(lastDoneCyc - k), 32'd268);
    check("t2_data", 32'(oReadData), 32'h0000_0005);
    check("t2_pulses", 32'(pulseCnt - p0), 32'd6);
    check("t2_timeout", 32'(lastDoneTo), 32'd0);

    // Poll limit reached with BF stuck high.
    nibQ = '{4'h8, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0};
    p0 = pulseCnt;
    startOp(1'b0, 1'b1, 3, 8'h80, 1'b1, k);
    toCycle(k + 66 + 2 * REREAD + 4);
    check("t3_done_latency", 32'(lastDoneCyc - k), 32'd268);
    check("t3_data", 32'(oReadData), 32'h0000_0080);
    check("t3_pulses", 32'(pulseCnt - p0), 32'd6);
    check("t3_timeout", 32'(lastDoneTo), 32'd1);

    // Start held through DONE: second op accepted only once IDLE is back,
    // then a mid-read pulse is ignored. BF set with poll off still completes.
    nibQ = '{4'h1, 4'h7, 4'hE, 4'h4};
    p0 = pulseCnt;
    d0 = doneCnt;
    iRS    = 1'b1;
    iPoll  = 1'b0;
    iStart = 1'b1;
    k      = cyc + 1;
    k2     = k + 67;
    scheduleOp(k, 1, 1'b1, 8'h17, 1'b0);
    scheduleOp(k2, 1, 1'b1, 8'hE4, 1'b0);
    toCycle(k2 + 5);
    iStart = 1'b0;
    toCycle(k2 + 30);
    iStart = 1'b1;
    iRS    = 1'b0;
    @(negedge Clock);
    iStart = 1'b0;
    toCycle(k2 + 90);
    check("t4_done_count", 32'(doneCnt - d0), 32'd2);
    check("t4_second_done", 32'(lastDoneCyc - k), 32'd133);
    check("t4_pulses", 32'(pulseCnt - p0), 32'd4);
    check("t4_data", 32'(oReadData), 32'h0000_00E4);

    // Reset during the second E pulse.
    nibQ = '{4'h3, 4'hC};
    p0 = pulseCnt;
    d0 = doneCnt;
    startOp(1'b1, 1'b0, 1, 8'h3C, 1'b0, k);
    toCycle(k + 58);
    #1 Reset = 1'b1;
    #1;
    check("t5_async_pins{E,RW,OE}", 32'({oLCD_Enabled, oLCD_RW, oLCD_DataOE}), 32'b001);
    check("t5_async_data", 32'(oReadData), 32'h0);
    clearFrom(k + 59);
    toCycle(k + 62);
    Reset = 1'b0;
    toCycle(k + 140);
    check("t5_no_done", 32'(doneCnt - d0), 32'd0);
    check("t5_pulses", 32'(pulseCnt - p0), 32'd2);
    check("t5_data_cleared", 32'(oReadData), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
